// File: rtl/quad_pkg.sv
// Shared constants and transition decoding for the quadrature decoder.
// The {a,b} Gray states advance 00 -> 01 -> 11 -> 10 -> 00 in the up direction.
package quad_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   localparam logic [1:0] GRAY_S0 = 2'b00;
   localparam logic [1:0] GRAY_S1 = 2'b01;
   localparam logic [1:0] GRAY_S2 = 2'b11;
   localparam logic [1:0] GRAY_S3 = 2'b10;

   typedef enum logic [1:0] {
      TR_IDLE = 2'd0,
      TR_UP   = 2'd1,
      TR_DN   = 2'd2,
      TR_ILL  = 2'd3
   } trans_t;

   function automatic logic [1:0] gray_next_up(input logic [1:0] s);
      logic [1:0] n;
      case (s)
         GRAY_S0: n = GRAY_S1;
         GRAY_S1: n = GRAY_S2;
         GRAY_S2: n = GRAY_S3;
         default: n = GRAY_S0;
      endcase
      return n;
   endfunction

   function automatic trans_t decode_trans(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
      trans_t t;
      if (prev_ab == cur_ab)
         t = TR_IDLE;
      else if ((prev_ab ^ cur_ab) == 2'b11)
         t = TR_ILL;
      else if (gray_next_up(prev_ab) == cur_ab)
         t = TR_UP;
      else
         t = TR_DN;
      return t;
   endfunction

endpackage

// File: rtl/quad_sync_filt.sv
// One quadrature channel: 2-flop synchronizer, then an optional stability filter
// compiled in only when QUAD_FILTER_EN is defined.
module quad_sync_filt
   import quad_pkg::*;
#(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic sync1_reg;
   logic sync2_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= din;
         sync2_reg <= sync1_reg;
      end
   end

`ifdef QUAD_FILTER_EN
   logic       filt_reg;
   logic       filt_next;
   logic [3:0] cnt_reg;
   logic [3:0] cnt_next;

   // A new level is accepted on the FILT_LEN-th consecutive differing sample.
   always_comb begin
      filt_next = filt_reg;
      cnt_next  = 4'd0;
      if (sync2_reg != filt_reg) begin
         if (cnt_reg == 4'(FILT_LEN - 1)) begin
            filt_next = sync2_reg;
         end else begin
            cnt_next = cnt_reg + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_reg <= 1'b0;
         cnt_reg  <= 4'd0;
      end else begin
         filt_reg <= filt_next;
         cnt_reg  <= cnt_next;
      end
   end

   assign dout = filt_reg;
`else
   assign dout = sync2_reg;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronized (optionally filtered) A/B channels drive a
// wrapping position counter. Optional glitch filter: QUAD_FILTER_EN.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int FILT_LEN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             qa,
   input  logic             qb,
   input  logic             clr,
   output logic             step,
   output logic             dir,
   output logic [CNT_W-1:0] pos,
   output logic             rc,
   output logic             err
);

   localparam logic [CNT_W-1:0] POS_MAX = {CNT_W{1'b1}};

   logic a_s;
   logic b_s;
   logic [1:0] cur_ab;

   quad_sync_filt #(.FILT_LEN(FILT_LEN)) u_sync_a (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (qa),
      .dout (a_s)
   );

   quad_sync_filt #(.FILT_LEN(FILT_LEN)) u_sync_b (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (qb),
      .dout (b_s)
   );

   assign cur_ab = {a_s, b_s};

   logic [1:0]       prev_ab_reg;
   logic             primed_reg;
   logic             step_reg,  step_next;
   logic             dir_reg,   dir_next;
   logic [CNT_W-1:0] pos_reg,   pos_next;
   logic             rc_reg,    rc_next;
   logic             err_reg,   err_next;
   trans_t           trans;

   always_comb begin
      trans     = primed_reg ? decode_trans(prev_ab_reg, cur_ab) : TR_IDLE;
      step_next = 1'b0;
      dir_next  = dir_reg;
      pos_next  = pos_reg;
      rc_next   = 1'b0;
      err_next  = err_reg;
      case (trans)
         TR_UP: begin
            step_next = 1'b1;
            dir_next  = DIR_UP;
            pos_next  = pos_reg + 1'b1;
            rc_next   = (pos_reg == POS_MAX);
         end
         TR_DN: begin
            step_next = 1'b1;
            dir_next  = DIR_DN;
            pos_next  = pos_reg - 1'b1;
            rc_next   = (pos_reg == '0);
         end
         TR_ILL:  err_next = 1'b1;
         default: ;
      endcase
      // Clear wins over the count, but step/dir still report the transition.
      if (clr) begin
         pos_next = '0;
         err_next = 1'b0;
         rc_next  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_ab_reg <= 2'b00;
         primed_reg  <= 1'b0;
         step_reg    <= 1'b0;
         dir_reg     <= 1'b0;
         pos_reg     <= '0;
         rc_reg      <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         prev_ab_reg <= cur_ab;
         primed_reg  <= 1'b1;
         step_reg    <= step_next;
         dir_reg     <= dir_next;
         pos_reg     <= pos_next;
         rc_reg      <= rc_next;
         err_reg     <= err_next;
      end
   end

   assign step = step_reg;
   assign dir  = dir_reg;
   assign pos  = pos_reg;
   assign rc   = rc_reg;
   assign err  = err_reg;

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, position counter width (2..32).
REQ-002 SHALL have parameter FILT_LEN, default 3, glitch-filter stability length in clocks (1..15), used only when filtering is compiled in.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports qa and qb, input, 1 bit each: asynchronous quadrature channels A and B.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of pos.
REQ-007 SHALL have port step, output, 1 bit: one-cycle pulse per valid quadrature transition.
REQ-008 SHALL have port dir, output, 1 bit: direction of the last valid step, 1 = up, 0 = down; held between steps.
REQ-009 SHALL have port pos, output, CNT_W bits: signed-agnostic wrapping position count.
REQ-010 SHALL have port rc, output, 1 bit: registered one-cycle pulse on pos wrap.
REQ-011 SHALL have port err, output, 1 bit: sticky illegal-transition flag, cleared by clr or reset.

Function
REQ-012 SHALL pass qa and qb through a 2-flop synchronizer each before any use.
REQ-013 SHALL register the previous synchronized pair prev_ab and decode {prev_ab, cur_ab}: 00->01->11->10->00 is up; the reverse is down; equal is idle; both bits changed is illegal.
REQ-014 SHALL, on up, assert step, set dir=1, and set pos=pos+1 in the same registered update.
REQ-015 SHALL, on down, assert step, set dir=0, and set pos=pos-1.
REQ-016 SHALL, on illegal, set err=1, leave pos and dir unchanged, not assert step, and update prev_ab.
REQ-017 SHALL wrap pos modulo 2^CNT_W and pulse rc for one cycle when pos goes from all-ones to 0 (up) or from 0 to all-ones (down).
REQ-018 SHALL make clr take priority over a simultaneous step: pos=0, err=0, rc=0; step and dir still reflect the decoded transition.
REQ-019 SHALL produce a step pulse exactly 3 clk cycles after a qa/qb input edge that meets setup, with filtering compiled out.
REQ-020 SHALL treat the first synchronized sample after reset release as a priming sample: load prev_ab, no decode, no step, no err.

Reset
REQ-021 SHALL, while rst_n=0, force step=0, dir=0, pos=0, rc=0, err=0, synchronizer flops=0, prev_ab=00, and primed=0.
REQ-022 SHALL abort any decode in progress on reset mid-operation, and SHALL re-prime per REQ-020 after release.

Configuration
REQ-023 SHALL, with QUAD_FILTER_EN defined, accept a changed synchronized channel value only after it is stable for FILT_LEN consecutive clocks, independently per channel; latency becomes 3+FILT_LEN cycles.
REQ-024 SHALL, without QUAD_FILTER_EN, omit the filter logic entirely and feed the synchronizer outputs directly to the decoder.

Structure
REQ-025 SHALL place the direction encoding constants (DIR_UP=1, DIR_DN=0) and the 2-bit Gray-state constants in a shared package, quad_pkg.
REQ-026 SHALL implement the synchronizer-plus-optional-filter for one channel as sub-module quad_sync_filt, instantiated twice.

Verification
REQ-027 SHALL cover: after reset, 8 forward sequence steps (00,01,11,10 repeated) -> 8 step pulses, dir=1, pos=8, err=0.
REQ-028 SHALL cover: from pos=0, one reverse step -> pos=2^CNT_W-1 (16'hFFFF), dir=0, rc pulses for exactly one cycle.
REQ-029 SHALL cover: from pos=16'hFFFF, one forward step -> pos=0, rc pulse, dir=1.
REQ-030 SHALL cover: an ab jump 00->11 -> err=1, pos unchanged, no step; a later clr -> err=0, pos=0.
REQ-031 SHALL cover: clr asserted in the same cycle as a decoded up step at pos=5 -> pos=0, step=1, dir=1.
REQ-032 SHALL cover: with QUAD_FILTER_EN and FILT_LEN=3, a 2-cycle glitch on qa -> no step; a 3-cycle stable change -> one step at 6 cycles latency.
